sample_block_buffer: RTL and testbench
======================================

Name: sample_block_buffer

Overview:
Ping-pong sample memory that sits on the responder end of the processor core's sample read port. It serves sample_axi_tread/sample_axi_taddress requests with sample_axi_tdata and signals unavailability on sample_axi_tbusy. A host-side valid/ready stream fills the idle bank sequentially. Banks swap when the core releases its block and the fill bank is full.

Parameters:
SAMPLE_BLOCK_ADDRESS_BIT_WIDTH, 8, address width of one block; DEPTH = 2**SAMPLE_BLOCK_ADDRESS_BIT_WIDTH samples per bank
SAMPLE_BIT_WIDTH, 16, sample word width

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
fill_tdata  in  SAMPLE_BIT_WIDTH  host sample to write
fill_tvalid  in  1  host sample valid
fill_tready  out  1  buffer accepts fill beat
sample_axi_taddress  in  SAMPLE_BLOCK_ADDRESS_BIT_WIDTH  core read address within the read bank
sample_axi_tread  in  1  core read strobe
sample_axi_tdata  out  SAMPLE_BIT_WIDTH  read data, one cycle after accepted strobe
sample_axi_tbusy  out  1  no readable bank, or swap in progress
block_done  in  1  one-cycle pulse: core has finished with the current read bank
read_bank  out  1  index of the bank the core is reading
underrun_count  out  8  saturating count of blocks released with no full fill bank

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state EMPTY, read_bank=0 (fill bank = 1), fill_count=0, fill_full=0, sample_axi_tdata=0, sample_axi_tbusy=1, underrun_count=0.
- fill_tready = !reset && !fill_full && state!=SWAP. It is 0 while reset is high.
- Fill: a beat is accepted when fill_tvalid && fill_tready. It writes mem[~read_bank][fill_count], and fill_count increments. The beat at fill_count==DEPTH-1 sets fill_full the next cycle; fill_count wraps to 0.
- Read: sample_axi_tread && !sample_axi_tbusy in cycle N gives sample_axi_tdata = mem[read_bank][taddress] in cycle N+1. Strobes while busy are ignored, and tdata holds its last value.
- sample_axi_tbusy = (state != READY), registered.
- States:
  - EMPTY: move to SWAP when fill_full, or when the last fill beat is accepted this cycle.
  - READY, block_done with fill full (or last beat this cycle): move to SWAP.
  - READY, block_done with fill not full: move to EMPTY, underrun_count+1, saturating at 255.
  - SWAP (exactly 1 cycle): read_bank toggles, fill_full and fill_count clear, then move to READY.
- block_done outside READY is ignored.
- Backpressure: a full fill bank holds fill_tready low indefinitely. No data is overwritten and none is dropped.
- Reset mid-operation discards any partial fill and any readable bank. It also cancels an in-flight read, so tdata returns to 0.

Decomposition:
- Package sample_buffer_pkg: state enum (EMPTY, READY, SWAP), DEPTH localparam function, underrun counter width constant.
- One sub-module: sdp_ram, a simple dual-port RAM with one write port, one read port and 1-cycle read latency.
  - Depth 2*DEPTH; address = {bank, offset}.
  - Instantiated once.

Test Plan:
- Reset for 3 cycles, then release -> tbusy=1, tdata=0, read_bank=0, underrun_count=0, fill_tready=1 from the first post-reset cycle.
- Stream 256 beats with value 3*i -> fill_tready=0 after the 256th accept, one SWAP cycle, tbusy=0 the following cycle, read_bank=1. Read addr 5 -> tdata=15 next cycle; read addr 255 -> 765.
- While reading, stream 256 beats of 1000+i -> fill_tready stays 0 after the 256th and tbusy stays 0. Pulse block_done -> 1-cycle tbusy, read_bank=0. Read addr 0 -> 1000.
- Underrun: in READY with fill_count=10, pulse block_done -> tbusy=1, underrun_count=1. Read strobe at addr 3 -> tdata unchanged. Complete the remaining 246 beats -> SWAP, READY; addr 3 returns the 4th filled value.
- Simultaneous: 256th fill beat accepted in the same cycle as block_done -> SWAP next cycle, underrun_count unchanged, the new bank is readable after it.
- Reset after 100 fill beats of an empty buffer -> state EMPTY, fill_count=0. Another 256 beats are needed before tbusy drops; the first 100 old values never appear.

Source files
------------

// File: rtl/sample_buffer_pkg.sv
// Shared types and constants for the ping-pong sample block buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sample_buffer_pkg;

    // Buffer control states: no readable bank, bank readable, one-cycle bank swap
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        READY = 2'd1,
        SWAP  = 2'd2
    } buf_state_t;

    // Width of the saturating underrun counter
    localparam int UNDERRUN_W = 8;

    // Samples per bank for a given block address width
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM holding both sample banks, addressed as {bank, offset}.
// Latency: write lands on the clock edge; read data is registered, 1 cycle after rd_vld.
// Backpressure: none; rd_dat holds its last value while rd_vld is low.
module sdp_ram #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_vld,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [2**AW];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Registered read port, holds the previous word when not reading
    always_ff @(posedge clk) begin
        if (rd_vld) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_block_buffer.sv
// Ping-pong sample memory: host stream fills the idle bank, core reads the other bank.
// Latency: read data 1 cycle after an accepted strobe; bank swap takes one cycle of tbusy.
// Backpressure: fill_tready drops while the fill bank is full or a swap is in progress.
module sample_block_buffer
    import sample_buffer_pkg::*;
#(
    parameter int SAMPLE_BLOCK_ADDRESS_BIT_WIDTH = 8,
    parameter int SAMPLE_BIT_WIDTH               = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [SAMPLE_BIT_WIDTH-1:0]               fill_tdata,
    input  logic                                      fill_tvalid,
    output logic                                      fill_tready,
    input  logic [SAMPLE_BLOCK_ADDRESS_BIT_WIDTH-1:0] sample_axi_taddress,
    input  logic                                      sample_axi_tread,
    output logic [SAMPLE_BIT_WIDTH-1:0]               sample_axi_tdata,
    output logic                                      sample_axi_tbusy,
    input  logic                                      block_done,
    output logic                                      read_bank,
    output logic [UNDERRUN_W-1:0]                     underrun_count
);

    localparam int AW    = SAMPLE_BLOCK_ADDRESS_BIT_WIDTH;
    localparam int DEPTH = depth_of(AW);

    buf_state_t            state;
    buf_state_t            state_nxt;
    logic [AW-1:0]         fill_count;
    logic                  fill_full;
    logic                  fill_fire;
    logic                  last_beat;
    logic                  fill_done;
    logic                  read_fire;
    logic                  underrun_inc;
    logic                  have_data;
    logic [SAMPLE_BIT_WIDTH-1:0] ram_rd_dat;

    assign fill_tready = !reset && !fill_full && (state != SWAP);
    assign fill_fire   = fill_tvalid && fill_tready;
    assign last_beat   = fill_fire && (int'(fill_count) == DEPTH - 1);
    // Fill bank counts as complete either already, or on the beat landing this cycle
    assign fill_done   = fill_full || last_beat;
    // tbusy is a flop mirroring state, so it already covers SWAP and EMPTY
    assign read_fire   = sample_axi_tread && !sample_axi_tbusy && !reset;

    // Next-state and underrun decision
    always_comb begin
        state_nxt    = state;
        underrun_inc = 1'b0;
        case (state)
            EMPTY: begin
                if (fill_done) begin
                    state_nxt = SWAP;
                end
            end
            READY: begin
                if (block_done) begin
                    if (fill_done) begin
                        state_nxt = SWAP;
                    end else begin
                        state_nxt    = EMPTY;
                        underrun_inc = 1'b1;
                    end
                end
            end
            SWAP: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // State register; tbusy is registered from the next state so it tracks state exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= EMPTY;
            sample_axi_tbusy <= 1'b1;
        end else begin
            state            <= state_nxt;
            sample_axi_tbusy <= (state_nxt != READY);
        end
    end

    // Fill pointer, fill-full flag and bank toggle on swap
    always_ff @(posedge clk) begin
        if (reset) begin
            read_bank  <= 1'b0;
            fill_count <= '0;
            fill_full  <= 1'b0;
        end else if (state == SWAP) begin
            read_bank  <= ~read_bank;
            fill_count <= '0;
            fill_full  <= 1'b0;
        end else if (fill_fire) begin
            fill_count <= fill_count + AW'(1);
            if (last_beat) begin
                fill_full <= 1'b1;
            end
        end
    end

    // Saturating count of blocks released without a full fill bank behind them
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (underrun_inc && (underrun_count != '1)) begin
            underrun_count <= underrun_count + UNDERRUN_W'(1);
        end
    end

    // Gates the RAM output to zero until the first read after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            have_data <= 1'b0;
        end else if (read_fire) begin
            have_data <= 1'b1;
        end
    end

    assign sample_axi_tdata = have_data ? ram_rd_dat : '0;

    sdp_ram #(
        .AW (AW + 1),
        .DW (SAMPLE_BIT_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_vld  (fill_fire),
        .wr_addr ({~read_bank, fill_count}),
        .wr_dat  (fill_tdata),
        .rd_vld  (read_fire),
        .rd_addr ({read_bank, sample_axi_taddress}),
        .rd_dat  (ram_rd_dat)
    );

endmodule

// File: tb/tb_sample_block_buffer.sv
// Self-checking bench for sample_block_buffer: reset table, directed corner cases, random traffic.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: fill beats are offered freely; the reference model decides acceptance.
module tb_sample_block_buffer;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] fill_tdata;
    logic          fill_tvalid;
    logic          fill_tready;
    logic [AW-1:0] sample_axi_taddress;
    logic          sample_axi_tread;
    logic [DW-1:0] sample_axi_tdata;
    logic          sample_axi_tbusy;
    logic          block_done;
    logic          read_bank;
    logic [7:0]    underrun_count;

    always #5 clk = ~clk;

    sample_block_buffer #(
        .SAMPLE_BLOCK_ADDRESS_BIT_WIDTH (AW),
        .SAMPLE_BIT_WIDTH               (DW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .fill_tdata          (fill_tdata),
        .fill_tvalid         (fill_tvalid),
        .fill_tready         (fill_tready),
        .sample_axi_taddress (sample_axi_taddress),
        .sample_axi_tread    (sample_axi_tread),
        .sample_axi_tdata    (sample_axi_tdata),
        .sample_axi_tbusy    (sample_axi_tbusy),
        .block_done          (block_done),
        .read_bank           (read_bank),
        .underrun_count      (underrun_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: two banks of samples plus a few flags describing availability
    int m_mem [2*DEPTH];
    int m_rb       = 0;
    int m_fill     = 0;
    int m_under    = 0;
    int m_tdata    = 0;
    bit m_full     = 0;
    bit m_readable = 0;
    bit m_swap     = 0;

    typedef struct {
        bit rst;
        bit fv;
        int fd;
        bit rd;
        int ra;
        bit bd;
        int e_busy;
        int e_tdata;
        int e_rb;
        int e_under;
        int e_tready;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance model and DUT, check outputs
    task automatic cycle(input bit rst, input bit fv, input int fd,
                         input bit rd, input int ra, input bit bd);
        bit exp_tready;
        bit fire;
        bit last;
        bit full_before;
        reset               = rst;
        fill_tvalid         = fv;
        fill_tdata          = DW'(fd);
        sample_axi_tread    = rd;
        sample_axi_taddress = AW'(ra);
        block_done          = bd;
        #1;
        exp_tready = !rst && !m_full && !m_swap;
        chk("fill_tready", int'(fill_tready), int'(exp_tready));
        fire = fv && exp_tready;
        @(posedge clk);
        if (rst) begin
            m_rb = 0; m_fill = 0; m_under = 0; m_tdata = 0;
            m_full = 0; m_readable = 0; m_swap = 0;
        end else begin
            if (rd && m_readable) begin
                m_tdata = m_mem[m_rb*DEPTH + ra];
            end
            full_before = m_full;
            last = fire && (m_fill == DEPTH - 1);
            if (fire) begin
                m_mem[(1 - m_rb)*DEPTH + m_fill] = fd & 32'hFFFF;
                m_fill = (m_fill + 1) % DEPTH;
                if (last) m_full = 1;
            end
            if (m_swap) begin
                m_rb = 1 - m_rb;
                m_full = 0;
                m_fill = 0;
                m_swap = 0;
                m_readable = 1;
            end else if (!m_readable) begin
                if (full_before || last) m_swap = 1;
            end else if (bd) begin
                m_readable = 0;
                if (full_before || last) m_swap = 1;
                else if (m_under < 255) m_under++;
            end
        end
        #1;
        chk("tbusy", int'(sample_axi_tbusy), int'(!m_readable));
        chk("tdata", int'(sample_axi_tdata), m_tdata);
        chk("read_bank", int'(read_bank), m_rb);
        chk("underrun", int'(underrun_count), m_under);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_at(input int a);
        cycle(0, 0, 0, 1, a, 0);
    endtask

    task automatic stream(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, base + step*i, 0, 0, 0);
        end
    endtask

    initial begin
        // Reset table: 3 reset cycles then quiet cycles where strobes and block_done are ignored
        tbl[0] = '{1, 1, 11, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 12, 1, 4, 1, 1, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 0,  1, 7, 0, 1, 0, 0, 0, 1};
        tbl[5] = '{0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 1};

        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].rst, tbl[i].fv, tbl[i].fd, tbl[i].rd, tbl[i].ra, tbl[i].bd);
            chk("tbl_busy", int'(sample_axi_tbusy), tbl[i].e_busy);
            chk("tbl_tdata", int'(sample_axi_tdata), tbl[i].e_tdata);
            chk("tbl_rb", int'(read_bank), tbl[i].e_rb);
            chk("tbl_under", int'(underrun_count), tbl[i].e_under);
            chk("tbl_tready", int'(fill_tready), tbl[i].e_tready);
        end

        // First block: 3*i, then swap and read back
        stream(DEPTH, 0, 3);
        chk("p2_busy_in_swap", int'(sample_axi_tbusy), 1);
        chk("p2_tready_low", int'(fill_tready), 0);
        idle();
        chk("p2_busy_ready", int'(sample_axi_tbusy), 0);
        chk("p2_rb", int'(read_bank), 1);
        rd_at(5);
        chk("p2_rd5", int'(sample_axi_tdata), 15);
        rd_at(255);
        chk("p2_rd255", int'(sample_axi_tdata), 765);

        // Fill behind the reader until the fill bank backs up, then release
        stream(DEPTH, 1000, 1);
        chk("p3_tready_low", int'(fill_tready), 0);
        chk("p3_busy", int'(sample_axi_tbusy), 0);
        cycle(0, 1, 9999, 0, 0, 0);
        chk("p3_still_full", int'(fill_tready), 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("p3_swap_busy", int'(sample_axi_tbusy), 1);
        idle();
        chk("p3_busy_after", int'(sample_axi_tbusy), 0);
        chk("p3_rb", int'(read_bank), 0);
        rd_at(0);
        chk("p3_rd0", int'(sample_axi_tdata), 1000);

        // Underrun: release with only 10 beats filled
        stream(10, 2000, 1);
        cycle(0, 0, 0, 0, 0, 1);
        chk("p4_busy", int'(sample_axi_tbusy), 1);
        chk("p4_under", int'(underrun_count), 1);
        rd_at(3);
        chk("p4_tdata_hold", int'(sample_axi_tdata), 1000);
        stream(DEPTH - 10, 2010, 1);
        idle();
        chk("p4_busy_ready", int'(sample_axi_tbusy), 0);
        chk("p4_rb", int'(read_bank), 1);
        rd_at(3);
        chk("p4_rd3", int'(sample_axi_tdata), 2003);

        // Last fill beat coincides with block_done
        stream(DEPTH - 1, 4000, 1);
        cycle(0, 1, 4255, 0, 0, 1);
        chk("p5_busy_swap", int'(sample_axi_tbusy), 1);
        chk("p5_under_same", int'(underrun_count), 1);
        idle();
        chk("p5_busy_ready", int'(sample_axi_tbusy), 0);
        chk("p5_rb", int'(read_bank), 0);
        rd_at(255);
        chk("p5_rd255", int'(sample_axi_tdata), 4255);

        // Reset mid-fill discards the partial block
        cycle(1, 0, 0, 1, 0, 0);
        chk("p6_tdata_reset", int'(sample_axi_tdata), 0);
        cycle(1, 0, 0, 0, 0, 0);
        stream(100, 5000, 1);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("p6_under_reset", int'(underrun_count), 0);
        stream(DEPTH - 1, 6000, 1);
        chk("p6_busy_partial", int'(sample_axi_tbusy), 1);
        cycle(0, 1, 6255, 0, 0, 0);
        idle();
        chk("p6_busy_ready", int'(sample_axi_tbusy), 0);
        chk("p6_rb", int'(read_bank), 1);
        rd_at(0);
        chk("p6_rd0", int'(sample_axi_tdata), 6000);
        rd_at(99);
        chk("p6_rd99", int'(sample_axi_tdata), 6099);

        // Random traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 65535)),
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 255)),
                  $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
